// File: rtl/nibble_demux_router.sv
// nibble_demux_router
//   Routes a valid/ready stream of 4-bit words into one of two independent
//   output FIFOs. The per-word select bit picks the FIFO (0 = A, 1 = B). Each
//   FIFO drives its own valid/ready output stream. A word accepted at edge N is
//   visible on the output in cycle N+1. There is no bypass path.
//
// Parameters
//   DEPTH  entries per output FIFO (power of two, >= 2)
//   CNT_W  width of the optional per-output transfer counters
//
// Ports
//   clk       rising-edge clock
//   rst_f     asynchronous active-low reset; empties both FIFOs
//   in_data   word to route
//   in_sel    destination of in_data (0 = A, 1 = B)
//   in_valid  in_data / in_sel are valid
//   in_ready  selected FIFO has room; the word is accepted this cycle
//   a_data    head of FIFO A (4'h0 when empty)
//   a_valid   FIFO A is non-empty
//   a_ready   consumer A takes the head
//   b_data    head of FIFO B (4'h0 when empty)
//   b_valid   FIFO B is non-empty
//   b_ready   consumer B takes the head
//   a_count   saturating count of words accepted into A (DEMUX_CNT_EN only)
//   b_count   saturating count of words accepted into B (DEMUX_CNT_EN only)
//
// Build option
//   DEMUX_CNT_EN  when defined, adds the a_count / b_count ports and counters.

module nibble_demux_router #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [3:0]       in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [3:0]       b_data,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Channel 0 is FIFO A, channel 1 is FIFO B.
  logic [1:0]      full;
  logic [1:0]      empty;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      out_ready;
  logic [1:0][3:0] head;

  assign out_ready = {b_ready, a_ready};

  // Only the addressed FIFO can stall the input. A full A never blocks B.
  assign in_ready = in_sel ? ~full[1] : ~full[0];

  assign a_data  = head[0];
  assign b_data  = head[1];
  assign a_valid = ~empty[0];
  assign b_valid = ~empty[1];

`ifdef DEMUX_CNT_EN
  logic [1:0][CNT_W-1:0] count;
  assign a_count = count[0];
  assign b_count = count[1];
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [3:0]    mem_reg [DEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic          sel_match;

      assign sel_match = (gi == 0) ? ~in_sel : in_sel;
      assign push[gi]  = in_valid & in_ready & sel_match;
      // A ready that arrives while the FIFO is empty is ignored.
      assign pop[gi]   = ~empty[gi] & out_ready[gi];

      // The pointers carry one extra wrap bit. This tells full apart from
      // empty when the addresses are equal.
      assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);
      assign full[gi]  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                         (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

      assign head[gi] = empty[gi] ? 4'h0 : mem_reg[rd_ptr_reg[AW-1:0]];

      always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      // Storage needs no reset. Entries are only visible between the pointers.
      always_ff @(posedge clk) begin
        if (push[gi]) mem_reg[wr_ptr_reg[AW-1:0]] <= in_data;
      end

`ifdef DEMUX_CNT_EN
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
          cnt_reg <= '0;
        end else if (push[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign count[gi] = cnt_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_nibble_demux_router.sv
// Testbench for nibble_demux_router.
// The reference model is two queues, one per output FIFO. The model process
// runs at each rising edge. It pushes each word that the model accepts and
// retires each head that the consumer takes. The monitor process runs at each
// falling edge. It compares the DUT outputs with the model heads and occupancy.

module tb_nibble_demux_router;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_f;
  logic [3:0]       in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a_data;
  logic             a_valid;
  logic             a_ready;
  logic [3:0]       b_data;
  logic             b_valid;
  logic             b_ready;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;
`endif

  nibble_demux_router #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
`ifdef DEMUX_CNT_EN
    ,
    .a_count  (a_count),
    .b_count  (b_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model state: the words that should sit in each FIFO, head first.
  logic [3:0] exp_a[$];
  logic [3:0] exp_b[$];
  int         cnt_a_m = 0;
  int         cnt_b_m = 0;
  bit         acc_flag = 1'b0;
  bit         mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model. A word is accepted when its FIFO holds fewer than DEPTH
  // words before this edge. The consumer takes the head when it is ready and
  // the FIFO was non-empty before this edge.
  always @(posedge clk) begin
    if (rst_f) begin
      acc_flag = in_valid && (in_sel ? (exp_b.size() < DEPTH) : (exp_a.size() < DEPTH));
      if (a_ready && exp_a.size() > 0) begin
        $display("pop  A %h", exp_a[0]);
        void'(exp_a.pop_front());
      end
      if (b_ready && exp_b.size() > 0) begin
        $display("pop  B %h", exp_b[0]);
        void'(exp_b.pop_front());
      end
      if (acc_flag) begin
        $display("push %s %h", in_sel ? "B" : "A", in_data);
        if (in_sel) begin
          exp_b.push_back(in_data);
          if (cnt_b_m < CNT_MAX) cnt_b_m++;
        end else begin
          exp_a.push_back(in_data);
          if (cnt_a_m < CNT_MAX) cnt_a_m++;
        end
      end
    end
  end

  // Monitor: compares the DUT outputs with the model in the middle of each cycle.
  always @(negedge clk) begin
    if (rst_f && mon_en) begin
      chk("in_ready", {31'd0, in_ready},
          {31'd0, in_sel ? (exp_b.size() < DEPTH) : (exp_a.size() < DEPTH)});
      chk("a_valid", {31'd0, a_valid}, {31'd0, exp_a.size() > 0});
      chk("a_data",  {28'd0, a_data},  {28'd0, (exp_a.size() > 0) ? exp_a[0] : 4'h0});
      chk("b_valid", {31'd0, b_valid}, {31'd0, exp_b.size() > 0});
      chk("b_data",  {28'd0, b_data},  {28'd0, (exp_b.size() > 0) ? exp_b[0] : 4'h0});
`ifdef DEMUX_CNT_EN
      chk("a_count", 32'(a_count), 32'(cnt_a_m));
      chk("b_count", 32'(b_count), 32'(cnt_b_m));
`endif
    end
  end

  // Holds one word on the input until the model accepts it. The wait is
  // bounded; when the bound runs out it records a failed check.
  task automatic send(input logic [3:0] d, input logic s, input bit rnd);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (rnd) begin
        a_ready = 1'($urandom_range(0, 1));
        b_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      if (acc_flag) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Idle cycles. The input bus carries random data and select with in_valid
  // low, and the DUT must ignore it.
  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data = 4'($urandom);
      in_sel  = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_f    = 1'b0;
    in_data  = 4'h0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1 rst_f = 1'b1;
    #1;
    chk("rst_a_valid",  {31'd0, a_valid},  32'd0);
    chk("rst_b_valid",  {31'd0, b_valid},  32'd0);
    chk("rst_a_data",   {28'd0, a_data},   32'd0);
    chk("rst_b_data",   {28'd0, b_data},   32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_CNT_EN
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_b_count", 32'(b_count), 32'd0);
`endif
    mon_en = 1'b1;
    idle(3);

    // Routing.
    a_ready = 1'b1;
    b_ready = 1'b1;
    send(4'h3, 1'b0, 1'b0);
    send(4'hA, 1'b1, 1'b0);
    idle(3);

    // Fill A and apply backpressure. B keeps flowing while A is full.
    a_ready = 1'b0;
    send(4'h1, 1'b0, 1'b0);
    send(4'h2, 1'b0, 1'b0);
    in_data  = 4'h3;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("a_full_stall", {31'd0, a_valid & ~in_ready}, 32'd1);
    end
    send(4'h4, 1'b1, 1'b0);
    a_ready = 1'b1;
    send(4'h3, 1'b0, 1'b0);
    idle(4);

    // Pointer wrap-around through B, with random readies on both outputs.
    for (int i = 0; i < 9; i++) send(4'(i), 1'b1, 1'b1);
    a_ready = 1'b1;
    b_ready = 1'b1;
    idle(4);

    // Push and pop on A in the same cycle while A holds one word.
    a_ready = 1'b0;
    send(4'h5, 1'b0, 1'b0);
    a_ready = 1'b1;
    send(4'h6, 1'b0, 1'b0);
    chk("simul_a_valid", {31'd0, a_valid}, 32'd1);
    chk("simul_a_head",  {28'd0, a_data},  32'h6);
    idle(3);

    // Reset pulse mid-stream, between two clock edges. The stored words are
    // discarded.
    a_ready = 1'b0;
    send(4'h7, 1'b0, 1'b0);
    send(4'h8, 1'b0, 1'b0);
    #1 rst_f = 1'b0;
    #1;
    chk("midrst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("midrst_a_data",  {28'd0, a_data},  32'd0);
    exp_a.delete();
    exp_b.delete();
    cnt_a_m = 0;
    cnt_b_m = 0;
    #1 rst_f = 1'b1;
    a_ready = 1'b1;
    idle(4);

    // Counter saturation: five accepts into A.
    for (int i = 0; i < 5; i++) send(4'($urandom), 1'b0, 1'b0);
`ifdef DEMUX_CNT_EN
    chk("a_count_sat", 32'(a_count), 32'(CNT_MAX));
`endif
    idle(3);

    // Random mixed traffic.
    for (int i = 0; i < 30; i++) send(4'($urandom), 1'($urandom), 1'b1);
    a_ready = 1'b1;
    b_ready = 1'b1;
    idle(6);
    chk("drain_a_valid", {31'd0, a_valid}, 32'd0);
    chk("drain_b_valid", {31'd0, b_valid}, 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
